// File: rtl/ps2_scan_decoder_pkg.sv
// Shared definitions for the PS/2 Set-2 scan decoder: scancodes, decoder states,
// register map, status bit positions and the packed key-event format.
package ps2_scan_decoder_pkg;

   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_E1     = 8'hE1;
   localparam logic [7:0] SC_AA     = 8'hAA;
   localparam logic [7:0] SC_FA     = 8'hFA;
   localparam logic [7:0] SC_FE     = 8'hFE;
   localparam logic [7:0] SC_EE     = 8'hEE;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;
   localparam logic [7:0] SC_PAUSE  = 8'h77;
   localparam logic [7:0] SC_OVF0   = 8'h00;
   localparam logic [7:0] SC_OVF1   = 8'hFF;

   // E1 is followed by seven more bytes that together mean Pause.
   localparam logic [2:0] SKIP_LEN = 3'd7;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_CODE   = 2'd1;
   localparam logic [1:0] REG_FLAGS  = 2'd2;
   localparam logic [1:0] REG_COUNT  = 2'd3;

   localparam int ST_NEMPTY   = 7;
   localparam int ST_FULL     = 6;
   localparam int ST_OVF      = 5;
   localparam int ST_ERR      = 4;
   localparam int ST_ALT      = 2;
   localparam int ST_CTRL     = 1;
   localparam int ST_SHIFT    = 0;
   localparam int CLR_OVF_BIT = 5;
   localparam int CLR_ERR_BIT = 4;

   typedef enum logic [2:0] {
      DEC_IDLE = 3'd0,
      DEC_E0   = 3'd1,
      DEC_F0   = 3'd2,
      DEC_E0F0 = 3'd3,
      DEC_SKIP = 3'd4
   } dec_state_e;

   typedef struct packed {
      logic       rel;
      logic       ext;
      logic [7:0] code;
   } key_event_t;

   // Frame layout {stop, parity, data[7:0], start}; parity is odd over data+parity.
   function automatic logic frame_ok(input logic [10:0] f);
      return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
   endfunction

endpackage

// File: rtl/ps2_scan_decoder_fifo.sv
// Synchronous key-event FIFO with first-word-fall-through head (0 when empty).
module ps2_scan_decoder_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      head_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   count_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  do_push;
   logic                  do_pop;

   assign full_o  = count_q[DEPTH_LOG2];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan decoder: frame check, prefix folding FSM, modifier tracking and a
// 4-register CPU view over the key-event FIFO.
module ps2_scan_decoder
   import ps2_scan_decoder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic [10:0] rx_frame,
   output logic        rx_ack,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [7:0]  dbw,
   output logic [7:0]  dbr,
   output logic [2:0]  dbg_state_o
);

   // Handshake: a frame is taken on the first edge rx_valid=1 while not busy; rx_ack
   // pulses the next cycle, and busy only clears once the receiver drops rx_valid.
   logic          busy_q;
   logic          pend_q;
   logic [10:0]   frame_q;
   dec_state_e    state_q, state_d;
   logic [2:0]    skip_q, skip_d;
   logic          shift_q, shift_d;
   logic          ctrl_q, ctrl_d;
   logic          alt_q, alt_d;
   logic          err_q;
   logic          ovf_q;
   logic [7:0]    dbr_q;

   logic [7:0]    rx_byte;
   logic          is_prefix;
   logic          use_idle;
   logic          ev_push;
   key_event_t    ev;
   key_event_t    head_ev;
   logic          bad_code;
   logic          set_err;
   logic          set_ovf;
   logic          clr_err;
   logic          clr_ovf;
   logic          pop_req;
   logic          fifo_full;
   logic          fifo_empty;
   logic [DEPTH_LOG2:0] fifo_count;
   logic [7:0]    status;
   logic [7:0]    rd_data;
   logic          unused_dbw_bits;

   assign rx_byte     = frame_q[8:1];
   assign is_prefix   = (rx_byte == SC_E0) || (rx_byte == SC_F0) || (rx_byte == SC_E1);
   assign rx_ack      = pend_q;
   assign dbr         = dbr_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d  = state_q;
      skip_d   = skip_q;
      ev_push  = 1'b0;
      ev       = '0;
      bad_code = 1'b0;
      set_err  = 1'b0;
      use_idle = 1'b0;
      if (pend_q) begin
         if (!frame_ok(frame_q)) begin
            set_err = 1'b1;
            state_d = DEC_IDLE;
            skip_d  = '0;
         end else begin
            case (state_q)
               DEC_IDLE: use_idle = 1'b1;
               DEC_E0: begin
                  if (rx_byte == SC_F0) begin
                     state_d = DEC_E0F0;
                  end else if (is_prefix) begin
                     use_idle = 1'b1;
                  end else begin
                     state_d = DEC_IDLE;
                     if (rx_byte != SC_LSHIFT) begin
                        ev_push = 1'b1;
                        ev      = '{rel: 1'b0, ext: 1'b1, code: rx_byte};
                     end
                  end
               end
               DEC_F0: begin
                  if (is_prefix) begin
                     use_idle = 1'b1;
                  end else begin
                     state_d = DEC_IDLE;
                     ev_push = 1'b1;
                     ev      = '{rel: 1'b1, ext: 1'b0, code: rx_byte};
                  end
               end
               DEC_E0F0: begin
                  if (is_prefix) begin
                     use_idle = 1'b1;
                  end else begin
                     state_d = DEC_IDLE;
                     if (rx_byte != SC_LSHIFT) begin
                        ev_push = 1'b1;
                        ev      = '{rel: 1'b1, ext: 1'b1, code: rx_byte};
                     end
                  end
               end
               DEC_SKIP: begin
                  // Pause bytes are swallowed whole, prefixes included.
                  if (skip_q <= 3'd1) begin
                     state_d = DEC_IDLE;
                     skip_d  = '0;
                     ev_push = 1'b1;
                     ev      = '{rel: 1'b0, ext: 1'b1, code: SC_PAUSE};
                  end else begin
                     skip_d = skip_q - 3'd1;
                  end
               end
               default: state_d = DEC_IDLE;
            endcase
            if (use_idle) begin
               state_d = DEC_IDLE;
               case (rx_byte)
                  SC_E0: state_d = DEC_E0;
                  SC_F0: state_d = DEC_F0;
                  SC_E1: begin
                     state_d = DEC_SKIP;
                     skip_d  = SKIP_LEN;
                  end
                  SC_OVF0, SC_OVF1:            bad_code = 1'b1;
                  SC_AA, SC_FA, SC_FE, SC_EE:  bad_code = 1'b0;
                  default: begin
                     ev_push = 1'b1;
                     ev      = '{rel: 1'b0, ext: 1'b0, code: rx_byte};
                  end
               endcase
            end
         end
      end
   end

   // Modifiers follow every decoded event, whether or not the FIFO had room for it.
   always_comb begin
      shift_d = shift_q;
      ctrl_d  = ctrl_q;
      alt_d   = alt_q;
      if (ev_push) begin
         if (!ev.ext && ((ev.code == SC_LSHIFT) || (ev.code == SC_RSHIFT))) begin
            shift_d = !ev.rel;
         end
         if (ev.code == SC_CTRL) begin
            ctrl_d = !ev.rel;
         end
         if (ev.code == SC_ALT) begin
            alt_d = !ev.rel;
         end
      end
   end

   assign pop_req         = we && (addr == REG_CODE);
   assign clr_ovf         = we && (addr == REG_COUNT) && dbw[CLR_OVF_BIT];
   assign clr_err         = we && (addr == REG_COUNT) && dbw[CLR_ERR_BIT];
   assign set_ovf         = bad_code || (ev_push && fifo_full && !pop_req);
   assign unused_dbw_bits = ^{dbw[7:6], dbw[3:0]};

   ps2_scan_decoder_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (10)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ev_push),
      .pop_i   (pop_req),
      .wdata_i (ev),
      .head_o  (head_ev),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      status            = '0;
      status[ST_NEMPTY] = !fifo_empty;
      status[ST_FULL]   = fifo_full;
      status[ST_OVF]    = ovf_q;
      status[ST_ERR]    = err_q;
      status[ST_ALT]    = alt_q;
      status[ST_CTRL]   = ctrl_q;
      status[ST_SHIFT]  = shift_q;
      case (addr)
         REG_STATUS: rd_data = status;
         REG_CODE:   rd_data = head_ev.code;
         REG_FLAGS:  rd_data = {head_ev.rel, head_ev.ext, 6'b0};
         default:    rd_data = 8'(fifo_count);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         pend_q  <= 1'b0;
         frame_q <= '0;
         state_q <= DEC_IDLE;
         skip_q  <= '0;
         shift_q <= 1'b0;
         ctrl_q  <= 1'b0;
         alt_q   <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         dbr_q   <= '0;
      end else begin
         pend_q <= 1'b0;
         if (rx_valid && !busy_q) begin
            busy_q  <= 1'b1;
            pend_q  <= 1'b1;
            frame_q <= rx_frame;
         end else if (!rx_valid) begin
            busy_q <= 1'b0;
         end
         state_q <= state_d;
         skip_q  <= skip_d;
         shift_q <= shift_d;
         ctrl_q  <= ctrl_d;
         alt_q   <= alt_d;
         // A flag being raised this cycle beats a CPU clear of the same flag.
         if (set_err) begin
            err_q <= 1'b1;
         end else if (clr_err) begin
            err_q <= 1'b0;
         end
         if (set_ovf) begin
            ovf_q <= 1'b1;
         end else if (clr_ovf) begin
            ovf_q <= 1'b0;
         end
         if (!we) begin
            dbr_q <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: table of byte sequences from reset plus
// hand-written FIFO, error, Pause and reset sequences.
module tb_ps2_scan_decoder;

   logic        clk;
   logic        rst_n;
   logic        rx_valid;
   logic [10:0] rx_frame;
   logic        rx_ack;
   logic [1:0]  addr;
   logic        we;
   logic [7:0]  dbw;
   logic [7:0]  dbr;
   logic [2:0]  dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];

   typedef struct {
      logic [23:0] seq;
      int          len;
      logic [7:0]  exp_status;
      logic [7:0]  exp_code;
      logic [7:0]  exp_flags;
      logic [7:0]  exp_count;
   } vec_t;

   vec_t vecs[15];

   ps2_scan_decoder #(.DEPTH_LOG2(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_valid    (rx_valid),
      .rx_frame    (rx_frame),
      .rx_ack      (rx_ack),
      .addr        (addr),
      .we          (we),
      .dbw         (dbw),
      .dbr         (dbr),
      .dbg_state_o (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Driver tasks
   function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par);
      logic p;
      p = ~(^d);
      if (bad_par) p = ~p;
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [10:0] f);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_frame = f;
      @(negedge clk);
      rx_valid = 1'b0;
      check("rx_ack_pulse_hi", 16'(rx_ack), 16'h1);
      @(negedge clk);
      check("rx_ack_pulse_lo", 16'(rx_ack), 16'h0);
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
      @(negedge clk);
      we   = 1'b0;
      addr = a;
      @(negedge clk);
      v = dbr;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      we   = 1'b1;
      addr = a;
      dbw  = d;
      @(negedge clk);
      we   = 1'b0;
   endtask

   task automatic check_regs(input string name, input logic [7:0] st, input logic [7:0] code,
                             input logic [7:0] flags, input logic [7:0] cnt);
      logic [7:0] v;
      read_reg(2'd0, v); check({name, "_status"}, 16'(v), 16'(st));
      read_reg(2'd1, v); check({name, "_code"},   16'(v), 16'(code));
      read_reg(2'd2, v); check({name, "_flags"},  16'(v), 16'(flags));
      read_reg(2'd3, v); check({name, "_count"},  16'(v), 16'(cnt));
   endtask

   initial begin
      logic [7:0]  v;
      logic [10:0] f;

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_frame = '0;
      addr     = 2'd0;
      we       = 1'b0;
      dbw      = '0;

      //                 seq        len status code  flags count
      vecs[0]  = '{24'h1C0000, 1, 8'h80, 8'h1C, 8'h00, 8'h01};
      vecs[1]  = '{24'hE0F075, 3, 8'h80, 8'h75, 8'hC0, 8'h01};
      vecs[2]  = '{24'hF01C00, 2, 8'h80, 8'h1C, 8'h80, 8'h01};
      vecs[3]  = '{24'hE07500, 2, 8'h80, 8'h75, 8'h40, 8'h01};
      vecs[4]  = '{24'hE01200, 2, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[5]  = '{24'hE0F012, 3, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[6]  = '{24'h120000, 1, 8'h81, 8'h12, 8'h00, 8'h01};
      vecs[7]  = '{24'hE01400, 2, 8'h82, 8'h14, 8'h40, 8'h01};
      vecs[8]  = '{24'h110000, 1, 8'h84, 8'h11, 8'h00, 8'h01};
      vecs[9]  = '{24'h000000, 1, 8'h20, 8'h00, 8'h00, 8'h00};
      vecs[10] = '{24'hAA0000, 1, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[11] = '{24'hF0E075, 3, 8'h80, 8'h75, 8'h40, 8'h01};
      vecs[12] = '{24'hE0E01C, 3, 8'h80, 8'h1C, 8'h40, 8'h01};
      vecs[13] = '{24'hFF0000, 1, 8'h20, 8'h00, 8'h00, 8'h00};
      vecs[14] = '{24'h59F059, 3, 8'h80, 8'h59, 8'h00, 8'h02};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("reset_rx_ack", 16'(rx_ack), 16'h0);
      check("reset_dbr", 16'(dbr), 16'h0);
      check("reset_state", 16'(dbg_state), 16'h0);
      check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00);

      for (int i = 0; i < 15; i++) begin
         do_reset();
         for (int j = 0; j < vecs[i].len; j++) begin
            send_frame(mk(vecs[i].seq[23-8*j -: 8], 1'b0));
         end
         check_regs($sformatf("vec%0d", i), vecs[i].exp_status, vecs[i].exp_code,
                    vecs[i].exp_flags, vecs[i].exp_count);
      end

      // Shift make then break
      do_reset();
      send_frame(mk(8'h12, 1'b0));
      read_reg(2'd0, v); check("shift_make_status", 16'(v), 16'h81);
      send_frame(mk(8'hF0, 1'b0));
      check("state_after_f0", 16'(dbg_state), 16'h2);
      send_frame(mk(8'h12, 1'b0));
      check_regs("shift_break", 8'h80, 8'h12, 8'h00, 8'h02);

      // Framing errors and sticky err clear
      do_reset();
      send_frame(mk(8'h1C, 1'b1));
      check_regs("bad_parity", 8'h10, 8'h00, 8'h00, 8'h00);
      write_reg(2'd3, 8'h10);
      read_reg(2'd0, v); check("err_cleared", 16'(v), 16'h00);
      f = mk(8'h1C, 1'b0);
      f[10] = 1'b0;
      send_frame(f);
      read_reg(2'd0, v); check("bad_stop_err", 16'(v), 16'h10);
      send_frame(mk(8'hE0, 1'b0));
      check("state_after_e0", 16'(dbg_state), 16'h1);
      send_frame(mk(8'h75, 1'b1));
      check("state_after_bad_frame", 16'(dbg_state), 16'h0);
      send_frame(mk(8'h75, 1'b0));
      check_regs("after_bad_in_e0", 8'h90, 8'h75, 8'h00, 8'h01);

      // Fill FIFO past full
      do_reset();
      for (int i = 0; i < 17; i++) begin
         send_frame(mk(8'h30 + 8'(i), 1'b0));
         if (i < 16) exp_q.push_back(8'h30 + 8'(i));
      end
      check_regs("full", 8'hE0, 8'h30, 8'h00, 8'h10);
      write_reg(2'd3, 8'h20);
      read_reg(2'd0, v); check("ovf_cleared", 16'(v), 16'hC0);

      // Push and pop in the same cycle at full
      @(negedge clk);
      rx_valid = 1'b1;
      rx_frame = mk(8'h55, 1'b0);
      @(negedge clk);
      rx_valid = 1'b0;
      we       = 1'b1;
      addr     = 2'd1;
      @(negedge clk);
      we = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(8'h55);
      check_regs("push_pop_full", 8'hC0, 8'h31, 8'h00, 8'h10);

      // Drain through the wrapped pointers
      for (int i = 0; i < 16; i++) begin
         read_reg(2'd1, v);
         check($sformatf("drain%0d", i), 16'(v), 16'(exp_q.pop_front()));
         write_reg(2'd1, 8'h00);
      end
      write_reg(2'd1, 8'h00);
      check_regs("pop_empty", 8'h00, 8'h00, 8'h00, 8'h00);

      // Pause sequence collapses to one event
      do_reset();
      send_frame(mk(8'hE1, 1'b0));
      send_frame(mk(8'h14, 1'b0));
      send_frame(mk(8'h77, 1'b0));
      send_frame(mk(8'hE1, 1'b0));
      send_frame(mk(8'hF0, 1'b0));
      send_frame(mk(8'h14, 1'b0));
      send_frame(mk(8'hF0, 1'b0));
      read_reg(2'd3, v); check("pause_no_early_event", 16'(v), 16'h00);
      send_frame(mk(8'h77, 1'b0));
      check_regs("pause", 8'h80, 8'h77, 8'h40, 8'h01);

      // Reset in the middle of a Pause sequence
      do_reset();
      send_frame(mk(8'hE1, 1'b0));
      check("state_skip", 16'(dbg_state), 16'h4);
      do_reset();
      check("state_after_reset", 16'(dbg_state), 16'h0);
      read_reg(2'd0, v); check("status_after_reset", 16'(v), 16'h00);
      send_frame(mk(8'h1C, 1'b0));
      check_regs("after_mid_reset", 8'h80, 8'h1C, 8'h00, 8'h01);

      // Final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
